// File: rtl/tof_pkg.sv
// Types and encodings shared by the ToF I2C arbiter and the ToF sensor FSMs.
package tof_pkg;

    typedef enum logic [1:0] {
        ARB,
        WAIT_LOW,
        ISSUE,
        DONE
    } arb_state_t;

    typedef struct packed {
        logic        is_read;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } i2c_txn_t;

    // Sensor register map entries the ToF FSM and config loader agree on.
    localparam logic [15:0] DATA_START_ADDR = 16'h0089;
    localparam logic [7:0]  CMD_STOP        = 8'h00;
    localparam logic [7:0]  CMD_CLR_IRQ     = 8'h01;
    localparam logic [7:0]  CMD_START       = 8'h40;

    function automatic i2c_txn_t make_txn(input logic is_read,
                                          input logic [15:0] addr,
                                          input logic [7:0] wdata);
        i2c_txn_t t;
        t.is_read = is_read;
        t.addr    = addr;
        t.wdata   = wdata;
        return t;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int j;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(i_ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/tof_i2c_arbiter.sv
// Shares one single-byte I2C master among N_REQ requesters, round-robin,
// sequencing the start/ready handshake with a start-to-ready watchdog.
module tof_i2c_arbiter
    import tof_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 200000,
    parameter int IDX_W       = $clog2(N_REQ)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ-1:0]       i_req_is_read,
    input  logic [N_REQ-1:0][15:0] i_req_addr,
    input  logic [N_REQ-1:0][7:0]  i_req_wdata,
    output logic [N_REQ-1:0]       o_gnt,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_err,
    output logic [7:0]             o_rdata,
    output logic                   o_busy,
    output logic                   o_m_start,
    output logic                   o_m_is_read,
    output logic [15:0]            o_m_register_address,
    output logic [7:0]             o_m_i2c_data,
    output logic                   o_m_nb_of_bytes,
    input  logic                   i_m_ready,
    input  logic                   i_m_error,
    input  logic [7:0]             i_m_rdata
);

    localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

    arb_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    i2c_txn_t         r_txn, w_txn_nxt;
    logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0] r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic [7:0]       r_rdata, w_rdata_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_m_start, w_m_start_nxt;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [IDX_W-1:0] w_arb_idx;
    logic             w_arb_any;
    logic             w_timeout;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // A zero TIMEOUT_CYC disables the watchdog entirely.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_txn_nxt     = r_txn;
        w_gnt_nxt     = r_gnt;
        w_done_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_m_start_nxt = r_m_start;
        case (r_state)
            ARB: begin
                if (w_arb_any) begin
                    w_txn_nxt   = make_txn(i_req_is_read[w_arb_idx],
                                           i_req_addr[w_arb_idx],
                                           i_req_wdata[w_arb_idx]);
                    w_gnt_nxt   = w_arb_gnt;
                    w_ptr_nxt   = (w_arb_idx == IDX_W'(N_REQ - 1)) ? '0 : w_arb_idx + IDX_W'(1);
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                // A ready still high from the last transfer must not complete this one.
                if (!i_m_ready) begin
                    w_m_start_nxt = 1'b1;
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (i_m_ready || i_m_error) begin
                    w_m_start_nxt = 1'b0;
                    w_err_nxt     = i_m_error;
                    w_done_nxt    = r_gnt;
                    if (r_txn.is_read) w_rdata_nxt = i_m_rdata;
                    w_state_nxt   = DONE;
                end else if (w_timeout) begin
                    w_m_start_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_done_nxt    = r_gnt;
                    w_state_nxt   = DONE;
                end
            end
            DONE: begin
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = ARB;
            end
            default: w_state_nxt = ARB;
        endcase
        w_busy_nxt = (w_state_nxt != ARB);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ARB;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_txn     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
            r_m_start <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_txn     <= w_txn_nxt;
            r_gnt     <= w_gnt_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_busy    <= w_busy_nxt;
            r_m_start <= w_m_start_nxt;
        end
    end

    assign o_gnt                = r_gnt;
    assign o_done               = r_done;
    assign o_err                = r_err;
    assign o_rdata              = r_rdata;
    assign o_busy               = r_busy;
    assign o_m_start            = r_m_start;
    assign o_m_is_read          = r_txn.is_read;
    assign o_m_register_address = r_txn.addr;
    assign o_m_i2c_data         = r_txn.wdata;
    assign o_m_nb_of_bytes      = 1'b0;

endmodule

// File: tb/tb_tof_i2c_arbiter.sv
// Scoreboard bench for tof_i2c_arbiter with a behavioural I2C master model.
module tb_tof_i2c_arbiter;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      i_req;
    logic [N-1:0]      i_req_is_read;
    logic [N-1:0][15:0] i_req_addr;
    logic [N-1:0][7:0] i_req_wdata;
    logic [N-1:0]      o_gnt;
    logic [N-1:0]      o_done;
    logic              o_err;
    logic [7:0]        o_rdata;
    logic              o_busy;
    logic              o_m_start;
    logic              o_m_is_read;
    logic [15:0]       o_m_register_address;
    logic [7:0]        o_m_i2c_data;
    logic              o_m_nb_of_bytes;
    logic              i_m_ready;
    logic              i_m_error;
    logic [7:0]        i_m_rdata;

    tof_i2c_arbiter #(
        .N_REQ       (N),
        .TIMEOUT_CYC (50)
    ) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_req                (i_req),
        .i_req_is_read        (i_req_is_read),
        .i_req_addr           (i_req_addr),
        .i_req_wdata          (i_req_wdata),
        .o_gnt                (o_gnt),
        .o_done               (o_done),
        .o_err                (o_err),
        .o_rdata              (o_rdata),
        .o_busy               (o_busy),
        .o_m_start            (o_m_start),
        .o_m_is_read          (o_m_is_read),
        .o_m_register_address (o_m_register_address),
        .o_m_i2c_data         (o_m_i2c_data),
        .o_m_nb_of_bytes      (o_m_nb_of_bytes),
        .i_m_ready            (i_m_ready),
        .i_m_error            (i_m_error),
        .i_m_rdata            (i_m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        rd;
        logic        err;
        logic [7:0]  rdata;
        logic [15:0] addr;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         mdl_delay = 3;
    int         mdl_mode  = 0;   // 0 normal, 1 error with ready, 2 never ready
    int         mdl_stale = 0;
    logic [7:0] mdl_rdata = 8'h00;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic push_exp(input int idx, input logic rd, input logic err,
                            input logic [7:0] rdata, input logic [15:0] addr);
        exp_t e;
        e.idx = idx; e.rd = rd; e.err = err; e.rdata = rdata; e.addr = addr;
        sb_q.push_back(e);
    endtask

    task automatic set_cfg(input int idx, input logic rd, input logic [15:0] addr,
                           input logic [7:0] wdata);
        i_req_is_read[idx] = rd;
        i_req_addr[idx]    = addr;
        i_req_wdata[idx]   = wdata;
    endtask

    task automatic wait_q(input int n, input int budget);
        int k;
        k = 0;
        while (sb_q.size() > n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk_eq("sb_drain", 32'(sb_q.size()), 32'(n));
    endtask

    task automatic wait_start(input int budget);
        int k;
        k = 0;
        while (!o_m_start && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk_eq("start_seen", 32'(o_m_start), 32'd1);
    endtask

    // Master model: ready rises mdl_delay cycles after start is seen, then
    // stays high mdl_stale cycles beyond the drop of start.
    initial begin
        i_m_ready = 1'b0;
        i_m_error = 1'b0;
        i_m_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (o_m_start) begin
                if (mdl_mode != 2) begin
                    repeat (mdl_delay) @(negedge clk);
                    if (o_m_start) begin
                        i_m_ready = 1'b1;
                        i_m_error = (mdl_mode == 1);
                        i_m_rdata = mdl_rdata;
                    end
                end
                for (int k = 0; k < 1000 && o_m_start; k++) @(negedge clk);
                repeat (mdl_stale) @(negedge clk);
                i_m_ready = 1'b0;
                i_m_error = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk_eq("gnt_onehot0", 32'($onehot0(o_gnt)), 32'd1);
            if (o_done != '0) begin
                if (sb_q.size() == 0) begin
                    chk_eq("unexpected_done", 32'(o_done), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk_eq("done_vec",    32'(o_done), 32'(1 << mon_e.idx));
                    chk_eq("done_err",    32'(o_err), 32'(mon_e.err));
                    chk_eq("done_rdata",  32'(o_rdata), 32'(mon_e.rdata));
                    chk_eq("done_gnt",    32'(o_gnt), 32'(o_done));
                    chk_eq("done_mstart", 32'(o_m_start), 32'd0);
                    chk_eq("done_busy",   32'(o_busy), 32'd1);
                    chk_eq("done_addr",   32'(o_m_register_address), 32'(mon_e.addr));
                    chk_eq("done_dir",    32'(o_m_is_read), 32'(mon_e.rd));
                end
            end else begin
                chk_eq("err_idle", 32'(o_err), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi;
        rst           = 1'b1;
        i_req         = '0;
        i_req_is_read = '0;
        i_req_addr    = '0;
        i_req_wdata   = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_gnt",    32'(o_gnt), 32'd0);
        chk_eq("rst_done",   32'(o_done), 32'd0);
        chk_eq("rst_err",    32'(o_err), 32'd0);
        chk_eq("rst_rdata",  32'(o_rdata), 32'd0);
        chk_eq("rst_busy",   32'(o_busy), 32'd0);
        chk_eq("rst_mstart", 32'(o_m_start), 32'd0);
        chk_eq("rst_maddr",  32'(o_m_register_address), 32'd0);
        chk_eq("rst_nb",     32'(o_m_nb_of_bytes), 32'd0);

        // contention: pointer starts at 0, so 0,1,2,3,0
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_cfg(i, 1'b0, 16'h1000 + 16'(i), 8'h20 + 8'(i));
        mdl_delay = 3;
        for (int k = 0; k < 5; k++) push_exp(k % N, 1'b0, 1'b0, 8'h00, 16'h1000 + 16'(k % N));
        i_req = 4'b1111;
        wait_q(0, 200);
        i_req = '0;
        repeat (2) @(negedge clk);

        // single write, req dropped while granted, address changed after grant
        set_cfg(0, 1'b0, 16'h7FFF, 8'h14);
        mdl_delay = 10;
        push_exp(0, 1'b0, 1'b0, 8'h00, 16'h7FFF);
        i_req = 4'b0001;
        @(negedge clk);
        chk_eq("wr_start_early", 32'(o_m_start), 32'd0);
        chk_eq("wr_gnt",         32'(o_gnt), 32'h1);
        chk_eq("wr_busy",        32'(o_busy), 32'd1);
        i_req = '0;
        @(negedge clk);
        chk_eq("wr_start_lat", 32'(o_m_start), 32'd1);
        chk_eq("wr_maddr",     32'(o_m_register_address), 32'h7FFF);
        chk_eq("wr_mdata",     32'(o_m_i2c_data), 32'h14);
        chk_eq("wr_mdir",      32'(o_m_is_read), 32'd0);
        i_req_addr[0] = 16'h1234;
        repeat (3) @(negedge clk);
        chk_eq("wr_addr_stable", 32'(o_m_register_address), 32'h7FFF);
        wait_q(0, 100);
        repeat (2) @(negedge clk);

        // single read on requester 2
        set_cfg(2, 1'b1, 16'h0400, 8'h00);
        mdl_delay = 4;
        mdl_rdata = 8'hA5;
        push_exp(2, 1'b1, 1'b0, 8'hA5, 16'h0400);
        i_req = 4'b0100;
        @(negedge clk);
        chk_eq("rd_gnt_arb", 32'(o_gnt), 32'h4);
        wait_q(0, 100);
        i_req = '0;
        @(negedge clk);
        chk_eq("rd_gnt_clear",  32'(o_gnt), 32'd0);
        chk_eq("rd_busy_clear", 32'(o_busy), 32'd0);
        chk_eq("rd_rdata_hold", 32'(o_rdata), 32'hA5);
        repeat (2) @(negedge clk);

        // stale ready: held high 5 cycles after the previous done
        set_cfg(3, 1'b0, 16'h0300, 8'h33);
        mdl_delay = 3;
        mdl_stale = 5;
        push_exp(3, 1'b0, 1'b0, 8'hA5, 16'h0300);
        i_req = 4'b1000;
        wait_q(0, 100);
        set_cfg(1, 1'b0, 16'h0100, 8'h11);
        push_exp(1, 1'b0, 1'b0, 8'hA5, 16'h0100);
        i_req = 4'b0010;
        mdl_stale = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_eq("stale_hold", 32'(o_m_start), 32'd0);
        end
        chk_eq("stale_gnt", 32'(o_gnt), 32'h2);
        @(negedge clk);
        chk_eq("stale_release", 32'(o_m_start), 32'd1);
        wait_q(0, 100);
        i_req = '0;
        repeat (2) @(negedge clk);

        // master error reported together with ready
        set_cfg(0, 1'b0, 16'h0010, 8'h55);
        mdl_mode  = 1;
        mdl_delay = 2;
        push_exp(0, 1'b0, 1'b1, 8'hA5, 16'h0010);
        i_req = 4'b0001;
        wait_q(0, 100);
        i_req    = '0;
        mdl_mode = 0;
        repeat (2) @(negedge clk);

        // timeout on requester 3 (read, rdata kept), then requester 0 served
        set_cfg(3, 1'b1, 16'h0500, 8'h00);
        set_cfg(0, 1'b1, 16'h0600, 8'h00);
        mdl_mode  = 2;
        mdl_delay = 3;
        mdl_rdata = 8'h3C;
        push_exp(3, 1'b1, 1'b1, 8'hA5, 16'h0500);
        push_exp(0, 1'b1, 1'b0, 8'h3C, 16'h0600);
        i_req = 4'b1001;
        wait_start(20);
        n_hi = 0;
        while (o_m_start && n_hi < 200) begin
            n_hi++;
            @(negedge clk);
        end
        chk_eq("to_start_width", 32'(n_hi), 32'd50);
        #1;
        chk_eq("to_first_done", 32'(sb_q.size()), 32'd1);
        mdl_mode = 0;
        i_req[3] = 1'b0;
        wait_q(0, 100);
        i_req = '0;
        repeat (2) @(negedge clk);

        // reset in the middle of ISSUE, then pointer restarts at 0
        set_cfg(1, 1'b0, 16'h0700, 8'h77);
        mdl_mode = 2;
        i_req = 4'b0010;
        wait_start(20);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_eq("mrst_mstart", 32'(o_m_start), 32'd0);
        chk_eq("mrst_gnt",    32'(o_gnt), 32'd0);
        chk_eq("mrst_done",   32'(o_done), 32'd0);
        chk_eq("mrst_err",    32'(o_err), 32'd0);
        chk_eq("mrst_busy",   32'(o_busy), 32'd0);
        chk_eq("mrst_rdata",  32'(o_rdata), 32'd0);
        chk_eq("mrst_maddr",  32'(o_m_register_address), 32'd0);
        mdl_mode = 0;
        set_cfg(3, 1'b0, 16'h0800, 8'h88);
        push_exp(1, 1'b0, 1'b0, 8'h00, 16'h0700);
        push_exp(3, 1'b0, 1'b0, 8'h00, 16'h0800);
        i_req = 4'b1010;
        @(negedge clk);
        rst = 1'b0;
        wait_q(1, 100);
        i_req[1] = 1'b0;
        wait_q(0, 100);
        i_req = '0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
